// File: rtl/mem_pkg.sv
// Shared definitions for the memory pipeline stages.
// Holds the default bus/tag widths and the FSM state encoding of the
// memory-access stage so the address-generation stage sees the same values.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_REG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus wait counter for the memory-access stage.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   clear_i  - restart counting from zero (entry to a bus transaction)
//   enable_i - count one more wait cycle
//   tc_o     - terminal count: counter holds TIMEOUT-1 (never set when TIMEOUT == 0)
module bus_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT disables the terminal count entirely.
  assign tc_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: takes one load/store at a time from the
// address-generation stage, runs it on a simple req/ack bus and returns
// load results through a writeback handshake.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   in_addr/in_dest_reg/in_data   - operation fields, in_store selects store
//   in_valid/in_ready             - upstream handshake (in_ready combinational)
//   bus_req/bus_we/bus_addr/bus_wdata - registered bus request
//   bus_rdata/bus_ack             - bus completion (ignored outside BUS)
//   wb_dest_reg/wb_data/wb_valid/wb_ready - load writeback
//   bus_err                       - one-cycle pulse when a request times out
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int REG_W   = MEM_REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [REG_W-1:0]  in_dest_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_store,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [REG_W-1:0]  wb_dest_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              bus_err
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_err_q, bus_err_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_dest_q, wb_dest_d;

  logic accept_s;
  logic cnt_clear_s;
  logic cnt_en_s;
  logic cnt_tc_s;

  // A held writeback retiring this edge frees the stage for a new operation.
  assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && wb_ready));
  assign accept_s = in_valid && in_ready;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clear_s),
    .enable_i (cnt_en_s),
    .tc_o     (cnt_tc_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dest_d      = dest_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_err_d   = 1'b0;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_valid_d = 1'b0;
      end
      ST_BUS: begin
        // An ack in the terminal cycle wins over the timeout.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (store_q) begin
            state_d = ST_IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus_rdata;
            wb_dest_d  = dest_q;
            state_d    = ST_HOLD;
          end
        end else if (cnt_tc_s) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (store_q) begin
            state_d = ST_IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = {DATA_W{1'b1}};
            wb_dest_d  = dest_q;
            state_d    = ST_HOLD;
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bus_req_d  = 1'b0;
        bus_we_d   = 1'b0;
        wb_valid_d = 1'b0;
      end
    endcase

    // Acceptance is only possible from IDLE or a retiring HOLD, so it may
    // override whatever the state decode chose above.
    if (accept_s) begin
      addr_d      = in_addr;
      dest_d      = in_dest_reg;
      wdata_d     = in_data;
      store_d     = in_store;
      bus_req_d   = 1'b1;
      bus_we_d    = in_store;
      cnt_clear_s = 1'b1;
      state_d     = ST_BUS;
    end else begin
      cnt_clear_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      dest_q     <= {REG_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      store_q    <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= {DATA_W{1'b0}};
      wb_dest_q  <= {REG_W{1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dest_q     <= dest_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_err_q  <= bus_err_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_err     = bus_err_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_dest_reg = wb_dest_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a
// transaction-level model.
module tb_memory_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_addr;
  logic [4:0]  in_dest_reg;
  logic [7:0]  in_data;
  logic        in_store;
  logic        in_valid;
  logic        in_ready;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic [4:0]  wb_dest_reg;
  logic [7:0]  wb_data;
  logic        wb_valid;
  logic        wb_ready;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage #(
    .ADDR_W (16), .DATA_W (8), .REG_W (5), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_addr (in_addr), .in_dest_reg (in_dest_reg), .in_data (in_data),
    .in_store (in_store), .in_valid (in_valid), .in_ready (in_ready),
    .bus_req (bus_req), .bus_we (bus_we), .bus_addr (bus_addr),
    .bus_wdata (bus_wdata), .bus_rdata (bus_rdata), .bus_ack (bus_ack),
    .wb_dest_reg (wb_dest_reg), .wb_data (wb_data), .wb_valid (wb_valid),
    .wb_ready (wb_ready), .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: an outstanding bus operation, its elapsed wait
  // cycles, and an optional pending writeback.
  logic        m_busy = 1'b0;
  logic        m_store = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_data = 8'h0;
  logic [4:0]  m_tag = 5'h0;
  int          m_wait = 0;
  logic        m_wb = 1'b0;
  logic [7:0]  m_wb_data = 8'h0;
  logic [4:0]  m_wb_tag = 5'h0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    logic can_take;
    can_take = !m_busy && (!m_wb || wb_ready);
    m_err = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_wb = 1'b0; m_wait = 0;
    end else if (m_busy) begin
      if (bus_ack) begin
        m_busy = 1'b0;
        if (!m_store) begin m_wb = 1'b1; m_wb_data = bus_rdata; m_wb_tag = m_tag; end
      end else if (TIMEOUT != 0 && m_wait == TIMEOUT - 1) begin
        m_busy = 1'b0; m_err = 1'b1;
        if (!m_store) begin m_wb = 1'b1; m_wb_data = 8'hFF; m_wb_tag = m_tag; end
      end else begin
        m_wait++;
      end
    end else begin
      if (m_wb && wb_ready) m_wb = 1'b0;
      if (in_valid && can_take) begin
        m_busy = 1'b1; m_store = in_store; m_addr = in_addr;
        m_data = in_data; m_tag = in_dest_reg; m_wait = 0;
      end
    end
    #1;
    chk("m_bus_req", 32'(bus_req), 32'(m_busy));
    chk("m_bus_err", 32'(bus_err), 32'(m_err));
    chk("m_wb_valid", 32'(wb_valid), 32'(m_wb));
    if (m_busy) begin
      chk("m_bus_addr", 32'(bus_addr), 32'(m_addr));
      chk("m_bus_we", 32'(bus_we), 32'(m_store));
      chk("m_bus_wdata", 32'(bus_wdata), 32'(m_data));
    end
    if (m_wb) begin
      chk("m_wb_data", 32'(wb_data), 32'(m_wb_data));
      chk("m_wb_dest", 32'(wb_dest_reg), 32'(m_wb_tag));
    end
    @(negedge clk);
    #2;
    chk("m_in_ready", 32'(in_ready), 32'(rst_n && !m_busy && (!m_wb || wb_ready)));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [4:0] t, input logic [7:0] d, input logic st);
    in_valid = 1'b1; in_addr = a; in_dest_reg = t; in_data = d; in_store = st;
  endtask

  initial begin
    int req_cycles;
    int errs;
    int ack_mode;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = 16'h0; in_dest_reg = 5'h0; in_data = 8'h0;
    in_store = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h0; wb_ready = 1'b1;

    // Reset state
    step(); step();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    rst_n = 1'b1;

    // Load with immediate ack
    step(); drive_op(16'h12F0, 5'd3, 8'h00, 1'b0); wb_ready = 1'b1;
    #1 chk("ld_in_ready", 32'(in_ready), 32'h1);
    step(); in_valid = 1'b0;
    chk("ld_bus_req", 32'(bus_req), 32'h1);
    chk("ld_bus_addr", 32'(bus_addr), 32'h12F0);
    chk("ld_bus_we", 32'(bus_we), 32'h0);
    bus_ack = 1'b1; bus_rdata = 8'hA5;
    step(); bus_ack = 1'b0;
    chk("ld_wb_valid", 32'(wb_valid), 32'h1);
    chk("ld_wb_data", 32'(wb_data), 32'hA5);
    chk("ld_wb_dest", 32'(wb_dest_reg), 32'h3);
    step();
    chk("ld_wb_drop", 32'(wb_valid), 32'h0);
    chk("ld_ready_after", 32'(in_ready), 32'h1);

    // Store acked after four wait cycles
    drive_op(16'h0200, 5'd0, 8'h5C, 1'b1);
    step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_bus_req", 32'(bus_req), 32'h1);
      chk("st_bus_we", 32'(bus_we), 32'h1);
      chk("st_bus_wdata", 32'(bus_wdata), 32'h5C);
      chk("st_bus_addr", 32'(bus_addr), 32'h0200);
      bus_ack = (i == 4);
      step();
    end
    bus_ack = 1'b0;
    chk("st_done_req", 32'(bus_req), 32'h0);
    chk("st_no_wb", 32'(wb_valid), 32'h0);
    step();
    chk("st_no_wb2", 32'(wb_valid), 32'h0);

    // Load held by wb_ready low, then retire and accept together
    drive_op(16'h0ABC, 5'd9, 8'h00, 1'b0); wb_ready = 1'b0;
    step(); in_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h66;
    step(); bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_wb_valid", 32'(wb_valid), 32'h1);
      chk("hold_wb_data", 32'(wb_data), 32'h66);
      chk("hold_wb_dest", 32'(wb_dest_reg), 32'h9);
      #1 chk("hold_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    chk("hold_wb_valid_last", 32'(wb_valid), 32'h1);
    wb_ready = 1'b1; drive_op(16'h0300, 5'd1, 8'h77, 1'b1);
    #1 chk("retire_in_ready", 32'(in_ready), 32'h1);
    step(); in_valid = 1'b0;
    chk("retire_wb_drop", 32'(wb_valid), 32'h0);
    chk("retire_bus_req", 32'(bus_req), 32'h1);
    chk("retire_bus_addr", 32'(bus_addr), 32'h0300);
    bus_ack = 1'b1;
    step(); bus_ack = 1'b0;
    chk("retire_done", 32'(bus_req), 32'h0);

    // Load that times out
    drive_op(16'h4444, 5'd7, 8'h00, 1'b0); wb_ready = 1'b0;
    step(); in_valid = 1'b0;
    req_cycles = 0; errs = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_req) req_cycles++;
      if (bus_err) errs++;
      if (wb_valid) break;
      step();
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd16);
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'h1);
    chk("to_wb_data", 32'(wb_data), 32'hFF);
    chk("to_wb_dest", 32'(wb_dest_reg), 32'h7);
    step();
    chk("to_err_one_cycle", 32'(bus_err), 32'h0);
    wb_ready = 1'b1;
    step(); step();

    // Ack arrives in the terminal cycle
    drive_op(16'h5555, 5'd2, 8'h00, 1'b0);
    step(); in_valid = 1'b0;
    errs = 0; req_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus_err) errs++;
      if (bus_req) req_cycles++;
      bus_ack = (i == 15); bus_rdata = 8'h3C;
      step();
    end
    bus_ack = 1'b0;
    chk("tc_req_cycles", 32'(req_cycles), 32'd16);
    chk("tc_wb_valid", 32'(wb_valid), 32'h1);
    chk("tc_wb_data", 32'(wb_data), 32'h3C);
    chk("tc_no_err", 32'(bus_err + 1'(errs != 0)), 32'h0);
    step();
    chk("tc_no_err_after", 32'(bus_err), 32'h0);

    // Reset mid-bus followed by a late ack
    drive_op(16'h7777, 5'd4, 8'h12, 1'b0); wb_ready = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("mid_bus_req", 32'(bus_req), 32'h1);
    rst_n = 1'b0;
    step(); rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 8'h99;
    chk("mid_rst_req", 32'(bus_req), 32'h0);
    chk("mid_rst_we", 32'(bus_we), 32'h0);
    chk("mid_rst_addr", 32'(bus_addr), 32'h0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("mid_rst_err", 32'(bus_err), 32'h0);
    chk("mid_rst_wb_data", 32'(wb_data), 32'h0);
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    step(); step(); bus_ack = 1'b0;
    chk("late_ack_wb", 32'(wb_valid), 32'h0);
    chk("late_ack_req", 32'(bus_req), 32'h0);
    chk("late_ack_err", 32'(bus_err), 32'h0);

    // Randomized traffic
    ack_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (k % 400 == 0) ack_mode = int'($urandom_range(0, 2));
      rst_n       = ($urandom_range(0, 299) != 0);
      in_valid    = 1'($urandom);
      in_addr     = 16'($urandom);
      in_dest_reg = 5'($urandom);
      in_data     = 8'($urandom);
      in_store    = 1'($urandom);
      wb_ready    = ($urandom_range(0, 3) != 0);
      bus_rdata   = 8'($urandom);
      case (ack_mode)
        0:       bus_ack = 1'($urandom);
        1:       bus_ack = ($urandom_range(0, 9) == 0);
        default: bus_ack = 1'b0;
      endcase
    end
    step();
    in_valid = 1'b0; bus_ack = 1'b0; rst_n = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Parameter: ADDR_W, 16, address width.
REQ-002 Parameter: DATA_W, 8, data width.
REQ-003 Parameter: REG_W, 5, destination-register tag width.
REQ-004 Parameter: TIMEOUT, 16, bus-wait cycles before abort; 0 disables the timeout.
REQ-005 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port: in_addr  in  ADDR_W  effective address from the address-generation stage.
REQ-008 Port: in_dest_reg  in  REG_W  load destination tag.
REQ-009 Port: in_data  in  DATA_W  store data.
REQ-010 Port: in_store  in  1  1 = store, 0 = load.
REQ-011 Port: in_valid / in_ready  in / out  1  upstream handshake; transfer when both high.
REQ-012 Port: bus_req, bus_we  out  1  memory request and write enable.
REQ-013 Port: bus_addr, bus_wdata  out  ADDR_W, DATA_W  request address and write data.
REQ-014 Port: bus_rdata, bus_ack  in  DATA_W, 1  read data and completion; bus_rdata valid only while bus_ack is high.
REQ-015 Port: wb_dest_reg, wb_data  out  REG_W, DATA_W  load writeback tag and value.
REQ-016 Port: wb_valid / wb_ready  out / in  1  writeback handshake.
REQ-017 Port: bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, BUS and HOLD; it handles one transaction at a time.
REQ-019 in_ready SHALL be combinational: high in IDLE, or in HOLD while wb_ready is high; low otherwise.
REQ-020 On accept, the block SHALL latch addr, dest_reg, data and store, then enter BUS.
REQ-021 In BUS, bus_req SHALL be high, with bus_we, bus_addr and bus_wdata driven from the latched fields and held stable until bus_ack or abort.
REQ-022 bus_ack SHALL be ignored outside BUS.
REQ-023 On bus_ack for a store, the FSM SHALL return to IDLE; no writeback is produced.
REQ-024 On bus_ack for a load, the block SHALL register bus_rdata into wb_data and the latched tag into wb_dest_reg, assert wb_valid, and enter HOLD.
REQ-025 Minimum load latency: accept at edge T, bus_ack high in cycle T+1, wb_valid high from edge T+2.
REQ-026 In HOLD, wb_valid, wb_data and wb_dest_reg SHALL stay stable until wb_ready is high.
REQ-027 In HOLD with wb_ready high and no in_valid, the FSM SHALL go to IDLE and wb_valid SHALL drop.
REQ-028 In HOLD with wb_ready and in_valid both high, the block SHALL retire the load and accept the new operation in the same edge, going directly to BUS.
REQ-029 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without bus_ack.
REQ-030 When TIMEOUT is nonzero and the counter reaches TIMEOUT-1 without bus_ack, the block SHALL:
- drop bus_req at the next edge;
- pulse bus_err for exactly one cycle;
- for a load, enter HOLD with wb_data = all-ones;
- for a store, enter IDLE.
REQ-031 If bus_ack arrives in the same cycle as the timeout, the block SHALL treat it as a normal completion with no bus_err.
REQ-032 Addresses SHALL pass through unmodified; the block performs no arithmetic on them.

Reset
REQ-033 While rst_n is low at a clock edge, the FSM SHALL go to IDLE; bus_req, bus_we, wb_valid and bus_err SHALL be 0; all data and address registers SHALL be 0.
REQ-034 Reset during BUS or HOLD SHALL abandon the transaction without bus_err; a bus_ack arriving after reset SHALL be ignored.
REQ-035 in_ready SHALL be low while rst_n is low.

Structure
REQ-036 The FSM state encoding and the ADDR_W, DATA_W and REG_W defaults SHALL live in a shared package, mem_pkg, shared with the address-generation stage.
REQ-037 The wait counter SHALL be a sub-module, bus_timeout_counter, with inputs clear/enable and a terminal-count output; everything else is flat.

Verification
REQ-038 Load 0x12F0 -> tag 3, bus_ack with rdata 0xA5 on the first BUS cycle, wb_ready=1 -> wb_valid at T+2 with wb_data=0xA5 and wb_dest_reg=3; in_ready high the following cycle.
REQ-039 Store 0x0200 <- 0x5C, ack after 4 wait cycles -> bus_we=1 and bus_wdata=0x5C stable for 5 cycles; no wb_valid.
REQ-040 Load completes, wb_ready held low 3 cycles then high with in_valid high -> wb outputs stable for 3 cycles; new op accepted on the retire edge; bus_req high the next cycle.
REQ-041 TIMEOUT=16, load, never ack -> bus_req high for 16 cycles, one bus_err pulse, wb_data=0xFF.
REQ-042 TIMEOUT=16, bus_ack in the terminal cycle -> normal completion, bus_err stays 0.
REQ-043 rst_n low for one cycle mid-BUS, then a late bus_ack -> IDLE, all outputs 0, late ack ignored, no writeback.
